// File: rtl/compare.sv
// Registered magnitude comparator with runtime unsigned/signed mode.
// One cycle of latency from the in_valid capture edge. Outputs: mutually
// exclusive lt/gt/eq flags plus the max and min operands.
// The result registers update only on valid cycles. out_valid tracks
// in_valid every cycle.
module compare #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic             out_valid
);

    logic             a_lt_b;
    logic             a_eq_b;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Signed order equals unsigned order once the sign bits are inverted,
    // so a single unsigned comparator serves both modes.
    always_comb begin
        a_key = A;
        b_key = B;
        if (sgn) begin
            a_key[WIDTH-1] = ~A[WIDTH-1];
            b_key[WIDTH-1] = ~B[WIDTH-1];
        end
        a_eq_b = (A == B);
        a_lt_b = (a_key < b_key);
    end

    // Result registers: capture on valid cycles, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt      <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            max_out <= '0;
            min_out <= '0;
        end else if (in_valid) begin
            lt      <= a_lt_b;
            gt      <= ~a_lt_b & ~a_eq_b;
            eq      <= a_eq_b;
            max_out <= a_lt_b ? B : A;
            min_out <= a_lt_b ? A : B;
        end
    end

    // Valid pipeline stage mirrors in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_compare.sv
// Directed and random checks for the registered comparator (WIDTH=4).
module tb_compare;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         lt, gt, eq, out_valid;
    logic [W-1:0] max_out, min_out;

    int total = 0;
    int bad = 0;

    compare #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sgn(sgn),
        .A(A), .B(B), .lt(lt), .gt(gt), .eq(eq),
        .max_out(max_out), .min_out(min_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         e_lt;
        logic         e_gt;
        logic         e_eq;
        logic [W-1:0] e_max;
        logic [W-1:0] e_min;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic v, input logic l, input logic g,
                           input logic e, input logic [W-1:0] mx, input logic [W-1:0] mn);
        chk({name, ".out_valid"}, 64'(out_valid), 64'(v));
        chk({name, ".lt"}, 64'(lt), 64'(l));
        chk({name, ".gt"}, 64'(gt), 64'(g));
        chk({name, ".eq"}, 64'(eq), 64'(e));
        chk({name, ".max"}, 64'(max_out), 64'(mx));
        chk({name, ".min"}, 64'(min_out), 64'(mn));
    endtask

    initial begin
        logic [W-1:0] ka, kb, ra, rb;
        logic         rs, m_lt, m_gt, m_eq;

        //          s     a        b        lt    gt    eq    max      min
        vecs[0]  = '{1'b0, 4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0001};
        vecs[1]  = '{1'b0, 4'b1010, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0110};
        vecs[2]  = '{1'b0, 4'b1111, 4'b1100, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1100};
        vecs[3]  = '{1'b0, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b1, 4'b1101, 4'b1101};
        vecs[4]  = '{1'b0, 4'b1100, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b0000};
        vecs[5]  = '{1'b1, 4'b1010, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b1010};
        vecs[6]  = '{1'b1, 4'b1111, 4'b1100, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1100};
        vecs[7]  = '{1'b1, 4'b1100, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1100};
        vecs[8]  = '{1'b1, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b1, 4'b1101, 4'b1101};
        vecs[9]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000};
        vecs[10] = '{1'b1, 4'b0111, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0111, 4'b1000};
        vecs[11] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000};
        vecs[12] = '{1'b1, 4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0001};

        // Power-on reset state.
        repeat (2) @(negedge clk);
        chk_all("por", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        rst_n = 1'b1;

        // Directed table, back-to-back valid cycles.
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            sgn = vecs[i].s;
            A   = vecs[i].a;
            B   = vecs[i].b;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].e_lt, vecs[i].e_gt,
                    vecs[i].e_eq, vecs[i].e_max, vecs[i].e_min);
        end

        // Hold: last capture was signed 0001 vs 0100 (lt); idle with changing operands.
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A   = 4'(4'b1111 - i);
            B   = 4'(i);
            sgn = i[0];
            @(negedge clk);
            chk_all($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0001);
        end

        // Asynchronous reset mid-cycle with nonzero outputs.
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_all("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Random throughput against an independent model.
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(1, 0));
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            sgn = rs; A = ra; B = rb;
            if (rs) begin
                m_lt = ($signed(ra) < $signed(rb));
                m_gt = ($signed(ra) > $signed(rb));
            end else begin
                m_lt = (ra < rb);
                m_gt = (ra > rb);
            end
            m_eq = (ra == rb);
            ka = m_lt ? rb : ra;
            kb = m_lt ? ra : rb;
            @(negedge clk);
            chk_all($sformatf("rnd%0d", i), 1'b1, m_lt, m_gt, m_eq, ka, kb);
            chk($sformatf("rnd%0d.onehot", i), 64'(int'(lt) + int'(gt) + int'(eq)), 64'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("tail.out_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compare.md
Name: compare

Overview:
- Registered magnitude comparator for two WIDTH-bit operands, default 4 bits.
- Produces mutually exclusive less-than, greater-than and equal flags, plus the max and min operands.
- Runtime selection between unsigned and two's-complement comparison.
- Used as a pipelined compare stage in datapaths; one cycle of latency, valid-qualified.

Parameters:
- WIDTH, 4, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle; capture on rising clk edge
- sgn  input  1  1 = two's-complement compare, 0 = unsigned compare; sampled with operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- lt  output  1  registered: A < B
- gt  output  1  registered: A > B
- eq  output  1  registered: A == B
- max_out  output  WIDTH  registered: larger of A, B under selected mode (A when equal)
- min_out  output  WIDTH  registered: smaller of A, B under selected mode (B when equal)
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset:
  - rst_n low asynchronously clears lt, gt, eq, out_valid to 0 and max_out, min_out to 0, immediately and independent of clk.
  - Deassertion is sampled on the next rising edge.
- Latency: exactly 1 cycle. Operands sampled at edge k with in_valid=1 appear on all outputs after edge k, with out_valid=1.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - lt/gt/eq/max_out/min_out hold their previous values; no update.
- Invariant: whenever out_valid=1, exactly one of lt, gt, eq is 1.
  - After reset and before the first valid capture, all three are 0.
- Unsigned mode (sgn=0): operands compared as natural numbers 0..2^WIDTH-1.
- Signed mode (sgn=1):
  - Operands compared as two's complement, range -2^(WIDTH-1)..2^(WIDTH-1)-1.
  - MSB differences resolve first: negative < non-negative.
- eq is mode-independent: bitwise equality.
- max_out/min_out follow the same ordering as lt/gt in the selected mode.
- Back-to-back: in_valid may be 1 every cycle; full throughput, no stall, no backpressure.
- Reset mid-stream: any captured result is discarded; out_valid=0 on the first edge after release unless in_valid=1 at that edge.
- No X propagation from flags: flags derive only from registered state.
- Implementation: purely synchronous datapath after the input register stage; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with outputs nonzero -> lt=gt=eq=0, out_valid=0, max_out=min_out=0 immediately, before the next clk edge.
- Unsigned sequence, sgn=0, in_valid=1 on consecutive cycles, each result one cycle later:
  - A=0001,B=0100 -> lt=1 gt=0 eq=0, max_out=0100, min_out=0001
  - A=1010,B=0110 -> gt=1, max_out=1010
  - A=1111,B=1100 -> gt=1
  - A=1101,B=1101 -> eq=1, max_out=min_out=1101
  - A=1100,B=0000 -> gt=1
- Signed sequence, sgn=1, same operand pairs:
  - A=1010,B=0110 -> lt=1, max_out=0110
  - A=1111,B=1100 -> gt=1 (-1 > -4)
  - A=1100,B=0000 -> lt=1, min_out=1100
  - A=1101,B=1101 -> eq=1
- Hold: capture A=0001,B=0100, then in_valid=0 for 3 cycles with changing A/B -> lt stays 1, out_valid=0 for those cycles.
- Boundaries, WIDTH=4:
  - sgn=0, A=0000,B=1111 -> lt=1
  - sgn=1, A=0111,B=1000 -> gt=1
  - sgn=1, A=1000,B=1000 -> eq=1
- Throughput: 16 random pairs with in_valid=1 every cycle (random sgn) -> 16 consecutive out_valid=1 cycles, each matching a reference model, exactly one flag high per cycle.
